fft_butterfly_stage: RTL and testbench



---
 rtl/fft_pkg.sv | 43 ++++
 rtl/fft_sat_scale.sv | 21 ++
 rtl/fft_butterfly_stage.sv | 121 ++++++++++++
 tb/tb_fft_butterfly_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared widths, saturation limits and the scale/saturate helper for the FFT datapath.
package fft_pkg;

    localparam int N      = 8;
    localparam int P      = 3;
    localparam int PROD_W = 2 * N - P + 1;
    localparam int SUM_W  = PROD_W + 1;
    localparam int BFLY   = 16;
    localparam int CNT_W  = (BFLY > 1) ? $clog2(BFLY) : 1;

    localparam int SAT_MAX_I = (2 ** (N - 1)) - 1;
    localparam int SAT_MIN_I = -(2 ** (N - 1));

    localparam logic signed [N-1:0]     SAT_MAX = N'(SAT_MAX_I);
    localparam logic signed [N-1:0]     SAT_MIN = N'(SAT_MIN_I);
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(SAT_MAX_I);
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(SAT_MIN_I);

    typedef struct packed {
        logic [N-1:0] value;
        logic         clip;
    } satResult_t;

    // Optional floor halving, then clamp a full-width sum back to the N-bit sample range.
    function automatic satResult_t scaleSat(input logic signed [SUM_W-1:0] sum,
                                            input logic doScale);
        logic signed [SUM_W-1:0] shifted;
        satResult_t r;
        shifted = doScale ? (sum >>> 1) : sum;
        if (shifted > SUM_MAX) begin
            r.value = SAT_MAX;
            r.clip  = 1'b1;
        end else if (shifted < SUM_MIN) begin
            r.value = SAT_MIN;
            r.clip  = 1'b1;
        end else begin
            r.value = shifted[N-1:0];
            r.clip  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sat_scale.sv
// One butterfly lane: rescale a registered sum and saturate it to the sample format.
module fft_sat_scale
    import fft_pkg::*;
#(
    parameter bit SCALE = 1'b1
) (
    input  logic signed [SUM_W-1:0] sum,
    output logic signed [N-1:0]     result,
    output logic                    clip
);

    satResult_t r;

    // Purely combinational shift and clamp; the caller registers the result.
    always_comb begin
        r      = scaleSat(sum, SCALE);
        result = r.value;
        clip   = r.clip;
    end

endmodule

// File: rtl/fft_butterfly_stage.sv
// Two-stage radix-2 DIT butterfly with elastic handshake, butterfly counter and sticky overflow.
module fft_butterfly_stage
    import fft_pkg::*;
#(
    parameter int p_inputWidth    = N,
    parameter int p_PointPosition = P,
    parameter int p_Scale         = 1,
    parameter int p_BflyPerStage  = BFLY
) (
    input  logic                                              i_clk,
    input  logic                                              i_rst,
    input  logic                                              i_valid,
    output logic                                              o_ready,
    input  logic signed [p_inputWidth-1:0]                    i_Ar,
    input  logic signed [p_inputWidth-1:0]                    i_Ai,
    input  logic signed [2*p_inputWidth-p_PointPosition:0]    i_Pr,
    input  logic signed [2*p_inputWidth-p_PointPosition:0]    i_Pi,
    output logic                                              o_valid,
    input  logic                                              i_ready,
    output logic signed [p_inputWidth-1:0]                    o_Xr,
    output logic signed [p_inputWidth-1:0]                    o_Xi,
    output logic signed [p_inputWidth-1:0]                    o_Yr,
    output logic signed [p_inputWidth-1:0]                    o_Yi,
    output logic                                              o_last,
    output logic                                              o_ovf,
    input  logic                                              i_ovfClr
);

    localparam int W  = 2 * p_inputWidth - p_PointPosition + 1;
    localparam int CW = (p_BflyPerStage > 1) ? $clog2(p_BflyPerStage) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(p_BflyPerStage - 1);

    logic signed [W:0] arExt, aiExt, prExt, piExt;
    logic signed [W:0] sumXr, sumXi, sumYr, sumYi;
    logic signed [W:0] s1Xr, s1Xi, s1Yr, s1Yi;
    logic              s1Valid;
    logic              s1Load, s2Load;
    logic signed [p_inputWidth-1:0] satXr, satXi, satYr, satYi;
    logic              clipXr, clipXi, clipYr, clipYi, anyClip;
    logic [CW-1:0]     bflyCnt;

    // Handshake: each stage advances when it is empty or its consumer is taking its beat.
    always_comb begin
        s2Load  = !o_valid || i_ready;
        s1Load  = !s1Valid || s2Load;
        o_ready = s1Load;
    end

    // Sign-extend A to the product width (binary points already aligned) and form the four sums.
    always_comb begin
        arExt = {{(W + 1 - p_inputWidth){i_Ar[p_inputWidth-1]}}, i_Ar};
        aiExt = {{(W + 1 - p_inputWidth){i_Ai[p_inputWidth-1]}}, i_Ai};
        prExt = {i_Pr[W-1], i_Pr};
        piExt = {i_Pi[W-1], i_Pi};
        sumXr = arExt + prExt;
        sumXi = aiExt + piExt;
        sumYr = arExt - prExt;
        sumYi = aiExt - piExt;
    end

    // Stage 1 register: full-precision sums plus their valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1Valid <= 1'b0;
            s1Xr    <= '0;
            s1Xi    <= '0;
            s1Yr    <= '0;
            s1Yi    <= '0;
        end else if (s1Load) begin
            s1Valid <= i_valid;
            if (i_valid) begin
                s1Xr <= sumXr;
                s1Xi <= sumXi;
                s1Yr <= sumYr;
                s1Yi <= sumYi;
            end
        end
    end

    fft_sat_scale #(.SCALE(p_Scale != 0)) uSatXr (.sum(s1Xr), .result(satXr), .clip(clipXr));
    fft_sat_scale #(.SCALE(p_Scale != 0)) uSatXi (.sum(s1Xi), .result(satXi), .clip(clipXi));
    fft_sat_scale #(.SCALE(p_Scale != 0)) uSatYr (.sum(s1Yr), .result(satYr), .clip(clipYr));
    fft_sat_scale #(.SCALE(p_Scale != 0)) uSatYi (.sum(s1Yi), .result(satYi), .clip(clipYi));

    assign anyClip = clipXr || clipXi || clipYr || clipYi;

    // Stage 2 register: saturated outputs, valid, last marker and the per-stage butterfly index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_Xr    <= '0;
            o_Xi    <= '0;
            o_Yr    <= '0;
            o_Yi    <= '0;
            bflyCnt <= '0;
        end else if (s2Load) begin
            o_valid <= s1Valid;
            o_last  <= s1Valid && (bflyCnt == LAST_IDX);
            if (s1Valid) begin
                o_Xr    <= satXr;
                o_Xi    <= satXi;
                o_Yr    <= satYr;
                o_Yi    <= satYi;
                bflyCnt <= (bflyCnt == LAST_IDX) ? '0 : bflyCnt + 1'b1;
            end
        end
    end

    // Sticky overflow: a clipping beat loaded into stage 2 sets it and beats a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (s2Load && s1Valid && anyClip) begin
            o_ovf <= 1'b1;
        end else if (i_ovfClr) begin
            o_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Directed bench for fft_butterfly_stage: one scaled and one unscaled instance on shared stimulus.
module tb_fft_butterfly_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic iReady = 1'b1;
    logic ovfClr = 1'b0;
    logic signed [7:0]  ar = '0, ai = '0;
    logic signed [13:0] pr = '0, pi = '0;

    logic oReady, oValid, oLast, oOvf;
    logic signed [7:0] xr, xi, yr, yi;
    logic nsReady, nsValid, nsLast, nsOvf;
    logic signed [7:0] nsXr, nsXi, nsYr, nsYi;

    int totalCount = 0;
    int badCount   = 0;

    always #5 clk = ~clk;

    fft_butterfly_stage #(.p_inputWidth(8), .p_PointPosition(3), .p_Scale(1), .p_BflyPerStage(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(oReady),
        .i_Ar(ar), .i_Ai(ai), .i_Pr(pr), .i_Pi(pi),
        .o_valid(oValid), .i_ready(iReady),
        .o_Xr(xr), .o_Xi(xi), .o_Yr(yr), .o_Yi(yi),
        .o_last(oLast), .o_ovf(oOvf), .i_ovfClr(ovfClr)
    );

    fft_butterfly_stage #(.p_inputWidth(8), .p_PointPosition(3), .p_Scale(0), .p_BflyPerStage(16)) dutNs (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(nsReady),
        .i_Ar(ar), .i_Ai(ai), .i_Pr(pr), .i_Pi(pi),
        .o_valid(nsValid), .i_ready(iReady),
        .o_Xr(nsXr), .o_Xi(nsXi), .o_Yr(nsYr), .o_Yi(nsYi),
        .o_last(nsLast), .o_ovf(nsOvf), .i_ovfClr(ovfClr)
    );

    // Count every comparison and report any disagreement.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalCount++;
        if (observed != expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference lane: integer butterfly sum, floor halving, clamp to 8 bits.
    function automatic int refLane(input int a, input int p, input bit sub, input bit scale);
        int s;
        s = sub ? a - p : a + p;
        if (scale) s = (s >= 0) ? s / 2 : -((1 - s) / 2);
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    function automatic int beatAr(input int k); return k * 5 - 40;   endfunction
    function automatic int beatAi(input int k); return 30 - k * 3;   endfunction
    function automatic int beatPr(input int k); return k * 7 - 60;   endfunction
    function automatic int beatPi(input int k); return 100 - k * 11; endfunction

    // Present one beat on the input bus.
    task automatic applyStimulus(input int aR, input int aI, input int pR, input int pI);
        ar    = 8'(aR);
        ai    = 8'(aI);
        pr    = 14'(pR);
        pi    = 14'(pI);
        valid = 1'b1;
    endtask

    task automatic doReset();
        rst = 1'b1; valid = 1'b0; ovfClr = 1'b0; iReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Send a single beat with i_ready=1; returns just after the edge where it reaches the outputs.
    task automatic sendOne(input int aR, input int aI, input int pR, input int pI, input bit clrAtLoad);
        @(posedge clk); #1 applyStimulus(aR, aI, pR, pI);
        @(posedge clk); #1 valid = 1'b0; ovfClr = clrAtLoad;
        @(posedge clk); #1 ovfClr = 1'b0;
    endtask

    task automatic expectBeat(input string tag, input int eXr, input int eXi, input int eYr, input int eYi);
        checkOutput({tag, ".valid"}, int'(oValid), 1);
        checkOutput({tag, ".xr"}, int'(xr), eXr);
        checkOutput({tag, ".xi"}, int'(xi), eXi);
        checkOutput({tag, ".yr"}, int'(yr), eYr);
        checkOutput({tag, ".yi"}, int'(yi), eYi);
    endtask

    // Stream nBeats through both instances, optionally with the 1,0,0,1 backpressure pattern.
    task automatic runStream(input string tag, input int nBeats, input bit bpMode);
        int q[$];
        int sent = 0, got = 0, inflight = 0, cyc = 0, k;
        bit inX, outX, stallPrev = 1'b0;
        int hold[4];
        iReady = 1'b1;
        applyStimulus(beatAr(0), beatAi(0), beatPr(0), beatPi(0));
        while (got < nBeats && cyc < 400) begin
            @(negedge clk);
            checkOutput({tag, ".ready"}, int'(oReady), (inflight == 2 && !iReady) ? 0 : 1);
            if (stallPrev) begin
                checkOutput({tag, ".holdValid"}, int'(oValid), 1);
                checkOutput({tag, ".holdXr"}, int'(xr), hold[0]);
                checkOutput({tag, ".holdYi"}, int'(yi), hold[3]);
            end
            outX = oValid && iReady;
            inX  = valid && oReady;
            if (outX) begin
                if (q.size() == 0) begin
                    checkOutput({tag, ".spurious"}, got, -1);
                end else begin
                    k = q.pop_front();
                    checkOutput({tag, ".xr"}, int'(xr), refLane(beatAr(k), beatPr(k), 1'b0, 1'b1));
                    checkOutput({tag, ".xi"}, int'(xi), refLane(beatAi(k), beatPi(k), 1'b0, 1'b1));
                    checkOutput({tag, ".yr"}, int'(yr), refLane(beatAr(k), beatPr(k), 1'b1, 1'b1));
                    checkOutput({tag, ".yi"}, int'(yi), refLane(beatAi(k), beatPi(k), 1'b1, 1'b1));
                    checkOutput({tag, ".nsXr"}, int'(nsXr), refLane(beatAr(k), beatPr(k), 1'b0, 1'b0));
                    checkOutput({tag, ".nsYi"}, int'(nsYi), refLane(beatAi(k), beatPi(k), 1'b1, 1'b0));
                end
                checkOutput({tag, ".last"}, int'(oLast), (got % 16 == 15) ? 1 : 0);
                got++;
            end
            stallPrev = oValid && !iReady;
            hold[0] = int'(xr); hold[1] = int'(xi); hold[2] = int'(yr); hold[3] = int'(yi);
            if (inX) begin
                q.push_back(sent);
                sent++;
            end
            inflight = inflight + int'(inX) - int'(outX);
            @(posedge clk); #1;
            cyc++;
            if (inX) begin
                if (sent < nBeats) applyStimulus(beatAr(sent), beatAi(sent), beatPr(sent), beatPi(sent));
                else valid = 1'b0;
            end
            iReady = bpMode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        end
        checkOutput({tag, ".count"}, got, nBeats);
        valid  = 1'b0;
        iReady = 1'b1;
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        checkOutput("rst.valid", int'(oValid), 0);
        checkOutput("rst.ready", int'(oReady), 1);
        checkOutput("rst.ovf",   int'(oOvf), 0);
        checkOutput("rst.last",  int'(oLast), 0);
        checkOutput("rst.xr",    int'(xr), 0);

        sendOne(16, 8, 40, -24, 1'b0);
        expectBeat("basic", 28, -8, -12, 16);
        checkOutput("basic.ovf",  int'(oOvf), 0);
        checkOutput("basic.last", int'(oLast), 0);

        sendOne(3, -3, 0, 0, 1'b0);
        expectBeat("floor", 1, -2, 1, -2);

        sendOne(127, -128, 100, -100, 1'b0);
        checkOutput("sat.nsXr", int'(nsXr), 127);
        checkOutput("sat.nsXi", int'(nsXi), -128);
        checkOutput("sat.nsYr", int'(nsYr), 27);
        checkOutput("sat.nsYi", int'(nsYi), -28);
        checkOutput("sat.nsOvf", int'(nsOvf), 1);
        expectBeat("satScaled", 113, -114, 13, -14);
        checkOutput("satScaled.ovf", int'(oOvf), 0);

        repeat (3) @(posedge clk);
        #1 checkOutput("sticky.nsOvf", int'(nsOvf), 1);
        ovfClr = 1'b1;
        @(posedge clk); #1 ovfClr = 1'b0;
        checkOutput("clear.nsOvf", int'(nsOvf), 0);

        sendOne(127, -128, 100, -100, 1'b1);
        checkOutput("clrSet.nsOvf", int'(nsOvf), 1);
        checkOutput("clrSet.ovf", int'(oOvf), 0);

        doReset();
        runStream("bp", 20, 1'b1);

        doReset();
        iReady = 1'b0;
        @(posedge clk); #1 applyStimulus(127, 127, 1000, 1000);
        repeat (3) @(posedge clk);
        #1 checkOutput("full.ready", int'(oReady), 0);
        checkOutput("full.ovf", int'(oOvf), 1);
        checkOutput("full.valid", int'(oValid), 1);
        rst = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("midRst.valid", int'(oValid), 0);
        checkOutput("midRst.ovf", int'(oOvf), 0);
        checkOutput("midRst.nsOvf", int'(nsOvf), 0);
        rst = 1'b0; iReady = 1'b1;
        runStream("cnt", 32, 1'b0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
